// File: rtl/branch_redirect_if.sv
// Interface between the EX-stage branch unit, the fetch/PC-update logic and the redirect controller.
// Perf-counter signals exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_redirect_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_pcsel;
    logic [31:0]     ex_target;
    logic            if_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic            target_err;
    logic            busy;
`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_valid, ex_is_branch, ex_pcsel, ex_target, if_ready,
        input  redirect_valid, redirect_pc, flush_ifid, flush_idex, target_err, busy,
        input  br_cnt, taken_cnt, stall_cnt
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_pcsel, ex_target, if_ready,
        output redirect_valid, redirect_pc, flush_ifid, flush_idex, target_err, busy,
        output br_cnt, taken_cnt, stall_cnt
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);

    modport master (
        output ex_valid, ex_is_branch, ex_pcsel, ex_target, if_ready,
        input  redirect_valid, redirect_pc, flush_ifid, flush_idex, target_err, busy
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_pcsel, ex_target, if_ready,
        output redirect_valid, redirect_pc, flush_ifid, flush_idex, target_err, busy
    );
`endif
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Fetch redirect / wrong-path squash sequencer for taken branches resolved in EX.
// Optional perf counters (br/taken/stall) are built when BRANCH_PERF_CNT_EN is defined.
module branch_redirect_ctrl #(
    parameter int PC_W      = 9,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input logic             clk,
    input logic             reset,
    branch_redirect_if.slave bus
);
    localparam int SQ_W = $clog2(FLUSH_CYC + 1);
    localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(FLUSH_CYC - 1);
    localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;

    function automatic logic target_bad(input logic [31:0] t);
        return (t[1:0] != 2'b00) || ((t >> PC_W) != 32'd0);
    endfunction

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        pc_d     = pc_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.ex_valid && bus.ex_pcsel) begin
                    state_d = REDIRECT;
                    pc_d    = {bus.ex_target[PC_W-1:2], 2'b00};
                    err_d   = target_bad(bus.ex_target);
                end
            end
            REDIRECT: begin
                if (bus.if_ready) begin
                    if (FLUSH_CYC > 1) begin
                        state_d  = SQUASH;
                        sq_cnt_d = SQ_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SQUASH: begin
                // EX contents here are wrong-path; only the countdown matters.
                if (sq_cnt_q == SQ_ONE) begin
                    state_d = IDLE;
                end
                sq_cnt_d = sq_cnt_q - SQ_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sq_cnt_q <= '0;
            pc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
        end
    end

    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.flush_idex     = (state_q == REDIRECT);
    assign bus.flush_ifid     = (state_q != IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.target_err     = err_q && (state_q == REDIRECT);
    assign bus.redirect_pc    = pc_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, taken_cnt_q, stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && bus.ex_valid && bus.ex_is_branch) begin
                br_cnt_q <= sat_inc(br_cnt_q);
            end
            if (state_q == IDLE && state_d == REDIRECT) begin
                taken_cnt_q <= sat_inc(taken_cnt_q);
            end
            if (state_q == REDIRECT && !bus.if_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign bus.br_cnt    = br_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = bus.ex_is_branch & (CNT_W > 0);
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_branch_redirect_ctrl;
    localparam int PC_W      = 9;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_redirect_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bif ();

    branch_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int checks = 0;
    int failures = 0;

    // Model: "in redirect" flag plus number of squash cycles still owed.
    bit              m_redir;
    int              m_sq;
    logic [PC_W-1:0] m_pc;
    bit              m_err;
    longint          m_br, m_taken, m_stall;

    task automatic model_step();
        if (reset) begin
            m_redir = 0; m_sq = 0; m_pc = '0; m_err = 0;
            m_br = 0; m_taken = 0; m_stall = 0;
        end else if (m_redir) begin
            if (!bif.if_ready) begin
                if (m_stall < CNT_MAX) m_stall++;
            end else begin
                m_redir = 0;
                m_sq = FLUSH_CYC - 1;
            end
        end else if (m_sq > 0) begin
            m_sq--;
        end else begin
            if (bif.ex_valid && bif.ex_is_branch && m_br < CNT_MAX) m_br++;
            if (bif.ex_valid && bif.ex_pcsel) begin
                m_redir = 1;
                m_pc = PC_W'(((bif.ex_target % (1 << PC_W)) / 4) * 4);
                m_err = (bif.ex_target % 4 != 0) || (bif.ex_target >= (1 << PC_W));
                if (m_taken < CNT_MAX) m_taken++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input bit br, input bit sel, input logic [31:0] tgt, input bit rdy);
        bif.ex_valid = v;
        bif.ex_is_branch = br;
        bif.ex_pcsel = sel;
        bif.ex_target = tgt;
        bif.if_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 32'h0, 1);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 1, 32'h40, 1);
        tick();
        tick();
        checks++;
        if ({bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.target_err, bif.busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                {bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.target_err, bif.busy});
        end
        checks++;
        if (bif.redirect_pc !== 9'h000) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=000", bif.redirect_pc);
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bif.br_cnt !== 0 || bif.taken_cnt !== 0 || bif.stall_cnt !== 0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", bif.br_cnt, bif.taken_cnt, bif.stall_cnt);
        end
`endif
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 1);
    endtask

    task automatic test_basic_redirect();
        do_reset();
        drive(1, 1, 1, 32'h40, 1);
        tick();
        drive(0, 0, 0, 32'h0, 1);
        checks++;
        if ({bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy, bif.target_err} !== 5'b11110
            || bif.redirect_pc !== 9'h040) begin
            failures++;
            $display("FAIL basic_redirect got=%b pc=%h exp=11110 pc=040",
                {bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy, bif.target_err}, bif.redirect_pc);
        end
        tick();
        checks++;
        if ({bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy} !== 4'b0101) begin
            failures++;
            $display("FAIL basic_squash got=%b exp=0101",
                {bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy});
        end
        tick();
        checks++;
        if ({bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL basic_idle got=%b exp=0000",
                {bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy});
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 1, 32'h40, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 9'h040) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/040", i, bif.redirect_valid, bif.redirect_pc);
            end
            bif.if_ready = (i == 3);
            tick();
        end
        checks++;
        if (bif.redirect_valid !== 1'b0 || bif.flush_ifid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%b%b exp=01", bif.redirect_valid, bif.flush_ifid);
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bif.stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL stall_cnt got=%0d exp=3", bif.stall_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1, 1, 1, 32'h0001_0042, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bif.redirect_pc !== 9'h040 || bif.target_err !== 1'b1 || bif.redirect_valid !== 1'b1) begin
                failures++;
                $display("FAIL misaligned cyc=%0d got=pc %h err %b rv %b exp=pc 040 err 1 rv 1",
                    i, bif.redirect_pc, bif.target_err, bif.redirect_valid);
            end
            bif.if_ready = (i == 2);
            tick();
        end
        tick();
    endtask

    task automatic test_squash_ignore();
        do_reset();
        drive(1, 1, 1, 32'h40, 1);
        tick();
        drive(1, 1, 1, 32'h80, 1);
        tick();
        checks++;
        if (bif.redirect_valid !== 1'b0 || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL squash_ignore got=rv %b busy %b exp=rv 0 busy 1", bif.redirect_valid, bif.busy);
        end
        tick();
        checks++;
        if (bif.busy !== 1'b0 || bif.redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL exit_edge_ignore got=busy %b rv %b exp=0 0", bif.busy, bif.redirect_valid);
        end
        tick();
        drive(0, 0, 0, 32'h0, 1);
        checks++;
        if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 9'h080) begin
            failures++;
            $display("FAIL after_idle_capture got=rv %b pc %h exp=rv 1 pc 080", bif.redirect_valid, bif.redirect_pc);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_during_redirect();
        do_reset();
        drive(1, 1, 1, 32'h40, 0);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.target_err, bif.busy} !== 5'b0
            || bif.redirect_pc !== 9'h000) begin
            failures++;
            $display("FAIL reset_mid_redirect got=%b pc %h exp=00000 pc 000",
                {bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.target_err, bif.busy}, bif.redirect_pc);
        end
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bif.redirect_valid !== 1'b0 || bif.busy !== 1'b0) begin
                failures++;
                $display("FAIL no_redirect_after_reset cyc=%0d got=rv %b busy %b exp=0 0",
                    i, bif.redirect_valid, bif.busy);
            end
        end
    endtask

    task automatic test_invalid_ignored();
        do_reset();
        drive(0, 1, 1, 32'h40, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bif.busy !== 1'b0 || bif.redirect_valid !== 1'b0) begin
                failures++;
                $display("FAIL invalid_ignored cyc=%0d got=busy %b rv %b exp=0 0", i, bif.busy, bif.redirect_valid);
            end
        end
    endtask

    task automatic test_branch_count();
        bit taken_pat [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
        int n;
        do_reset();
        for (int b = 0; b < 10; b++) begin
            drive(1, 1, taken_pat[b], 32'h100 + 32'(b * 4), 1);
            tick();
            drive(0, 0, 0, 32'h0, 1);
            n = 0;
            while (bif.busy && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 10) begin
                failures++;
                $display("FAIL branch_drain b=%0d got=busy after %0d cycles exp=idle", b, n);
            end
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bif.br_cnt !== 32'd10 || bif.taken_cnt !== 32'd4) begin
            failures++;
            $display("FAIL branch_count got=br %0d taken %0d exp=br 10 taken 4", bif.br_cnt, bif.taken_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 127) * 4);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt,
                  $urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (bif.redirect_valid !== m_redir || bif.flush_idex !== m_redir
                || bif.flush_ifid !== (m_redir || m_sq > 0) || bif.busy !== (m_redir || m_sq > 0)) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d got=rv %b fi %b fx %b busy %b exp=redir %b sq %0d",
                    c, bif.redirect_valid, bif.flush_ifid, bif.flush_idex, bif.busy, m_redir, m_sq);
            end
            checks++;
            if (bif.redirect_pc !== m_pc || bif.target_err !== (m_redir && m_err)) begin
                failures++;
                $display("FAIL rnd_target cyc=%0d got=pc %h err %b exp=pc %h err %b",
                    c, bif.redirect_pc, bif.target_err, m_pc, m_redir && m_err);
            end
`ifdef BRANCH_PERF_CNT_EN
            checks++;
            if (bif.br_cnt !== 32'(m_br) || bif.taken_cnt !== 32'(m_taken) || bif.stall_cnt !== 32'(m_stall)) begin
                failures++;
                $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                    bif.br_cnt, bif.taken_cnt, bif.stall_cnt, m_br, m_taken, m_stall);
            end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 32'h0, 1);
        test_reset();
        test_basic_redirect();
        test_stall();
        test_misaligned();
        test_squash_ignore();
        test_reset_during_redirect();
        test_invalid_ignored();
        test_branch_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
